matmul_job_sequencer: RTL and testbench



---
 rtl/matmul_job_sequencer.sv | 172 +++++++++++++++++
 tb/tb_matmul_job_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/matmul_job_sequencer.sv
// matmul_job_sequencer: runs one HIR matmul kernel job at a time.
// Accepts a job from the host and hands memory ownership to the kernel.
// Issues a single-cycle tstart, then tracks every banked result write in a
// coverage bitmap. The run ends on completion, abort or timeout, and the
// status/cycle report is held on a valid/ready handshake.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   job_valid/job_ready host job request handshake
//   abort               host abort of the current run
//   kern_tstart         one-cycle start pulse to the kernel
//   mem_sel             1 = kernel owns operand/result memories
//   kern_wr_en          per-bank result write strobe
//   kern_wr_addr        per-bank result address, bank b at [b*ADDR_W +: ADDR_W]
//   done_valid/ready    report handshake
//   done_status         0 ok, 1 timeout, 2 duplicate write, 3 aborted
//   done_cycles         cycles from tstart to exit, inclusive
module matmul_job_sequencer #(
    parameter int unsigned BANKS   = 16,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned TIMEOUT = 4096,
    parameter int unsigned CYC_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      job_valid,
    output logic                      job_ready,
    input  logic                      abort,
    output logic                      kern_tstart,
    output logic                      mem_sel,
    input  logic [BANKS-1:0]          kern_wr_en,
    input  logic [BANKS*ADDR_W-1:0]   kern_wr_addr,
    output logic                      done_valid,
    input  logic                      done_ready,
    output logic [1:0]                done_status,
    output logic [CYC_W-1:0]          done_cycles
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    localparam logic [CYC_W-1:0] CNT_MAX     = '1;
    localparam logic [CYC_W-1:0] CNT_TIMEOUT = CYC_W'(TIMEOUT);

    localparam logic [1:0] STAT_OK      = 2'd0;
    localparam logic [1:0] STAT_TIMEOUT = 2'd1;
    localparam logic [1:0] STAT_DUP     = 2'd2;
    localparam logic [1:0] STAT_ABORT   = 2'd3;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ARM    = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_REPORT = 3'd4;

    logic [2:0]                  state_q, state_d;
    logic [BANKS-1:0][DEPTH-1:0] map_q, map_d, map_upd;
    logic                        dup_q, dup_d, dup_hit;
    logic [CYC_W-1:0]            cnt_q, cnt_d;
    logic                        job_ready_d, kern_tstart_d, mem_sel_d, done_valid_d;
    logic [1:0]                  done_status_d;
    logic [CYC_W-1:0]            done_cycles_d;
    logic                        map_full;

    // Merge this cycle's writes into the bitmap; flag any bit already set.
    always_comb begin
        map_upd = map_q;
        dup_hit = 1'b0;
        for (int b = 0; b < int'(BANKS); b++) begin
            if (kern_wr_en[b]) begin
                if (map_q[b][kern_wr_addr[b*ADDR_W +: ADDR_W]]) begin
                    dup_hit = 1'b1;
                end
                map_upd[b][kern_wr_addr[b*ADDR_W +: ADDR_W]] = 1'b1;
            end
        end
        map_full = &map_upd;
    end

    // Next-state and next registered-output values.
    always_comb begin
        state_d       = state_q;
        map_d         = map_q;
        dup_d         = dup_q;
        cnt_d         = cnt_q;
        job_ready_d   = job_ready;
        kern_tstart_d = 1'b0;
        mem_sel_d     = mem_sel;
        done_valid_d  = done_valid;
        done_status_d = done_status;
        done_cycles_d = done_cycles;

        case (state_q)
            S_IDLE: begin
                if (job_valid && job_ready) begin
                    state_d     = S_ARM;
                    map_d       = '0;
                    dup_d       = 1'b0;
                    cnt_d       = '0;
                    job_ready_d = 1'b0;
                    mem_sel_d   = 1'b1;
                end
            end
            // Guard cycle: memory muxes settle before the kernel starts.
            S_ARM: begin
                state_d       = S_START;
                kern_tstart_d = 1'b1;
                cnt_d         = CYC_W'(1);
            end
            S_START, S_RUN: begin
                state_d = S_RUN;
                map_d   = map_upd;
                dup_d   = dup_q | dup_hit;
                cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CYC_W'(1);
                // Exit priority: full > abort > timeout.
                if (map_full || abort || (cnt_q == CNT_TIMEOUT)) begin
                    state_d       = S_REPORT;
                    mem_sel_d     = 1'b0;
                    done_valid_d  = 1'b1;
                    done_cycles_d = cnt_q;
                    if (map_full) begin
                        done_status_d = (dup_q | dup_hit) ? STAT_DUP : STAT_OK;
                    end else if (abort) begin
                        done_status_d = STAT_ABORT;
                    end else begin
                        done_status_d = STAT_TIMEOUT;
                    end
                end
            end
            S_REPORT: begin
                if (done_ready) begin
                    state_d      = S_IDLE;
                    done_valid_d = 1'b0;
                    job_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d      = S_IDLE;
                job_ready_d  = 1'b1;
                mem_sel_d    = 1'b0;
                done_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            map_q       <= '0;
            dup_q       <= 1'b0;
            cnt_q       <= '0;
            job_ready   <= 1'b1;
            kern_tstart <= 1'b0;
            mem_sel     <= 1'b0;
            done_valid  <= 1'b0;
            done_status <= 2'd0;
            done_cycles <= '0;
        end else begin
            state_q     <= state_d;
            map_q       <= map_d;
            dup_q       <= dup_d;
            cnt_q       <= cnt_d;
            job_ready   <= job_ready_d;
            kern_tstart <= kern_tstart_d;
            mem_sel     <= mem_sel_d;
            done_valid  <= done_valid_d;
            done_status <= done_status_d;
            done_cycles <= done_cycles_d;
        end
    end

endmodule

// File: tb/tb_matmul_job_sequencer.sv
// Directed testbench for matmul_job_sequencer (TIMEOUT shortened to 64).
module tb_matmul_job_sequencer;

    logic        clk;
    logic        rst_n;
    logic        job_valid;
    logic        job_ready;
    logic        abort;
    logic        kern_tstart;
    logic        mem_sel;
    logic [15:0] kern_wr_en;
    logic [63:0] kern_wr_addr;
    logic        done_valid;
    logic        done_ready;
    logic [1:0]  done_status;
    logic [15:0] done_cycles;

    int vectors;
    int miscompares;

    matmul_job_sequencer #(
        .BANKS   (16),
        .ADDR_W  (4),
        .TIMEOUT (64),
        .CYC_W   (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .job_valid    (job_valid),
        .job_ready    (job_ready),
        .abort        (abort),
        .kern_tstart  (kern_tstart),
        .mem_sel      (mem_sel),
        .kern_wr_en   (kern_wr_en),
        .kern_wr_addr (kern_wr_addr),
        .done_valid   (done_valid),
        .done_ready   (done_ready),
        .done_status  (done_status),
        .done_cycles  (done_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of writes (all banks share addr a) and optional abort.
    task automatic wr_cycle(input logic [15:0] en, input logic [3:0] a, input logic ab);
        kern_wr_en   = en;
        kern_wr_addr = {16{a}};
        abort        = ab;
        tick();
        kern_wr_en   = '0;
        kern_wr_addr = '0;
        abort        = 1'b0;
    endtask

    // Cycle 0 handshake, cycle 1 ARM, returns in cycle 2 (START, counter 1).
    task automatic start_job(input string tag);
        chk({tag, "_jr_idle"}, 32'(job_ready), 32'd1);
        job_valid = 1'b1;
        tick();
        job_valid = 1'b0;
        chk({tag, "_arm_memsel"}, 32'(mem_sel), 32'd1);
        chk({tag, "_arm_tstart"}, 32'(kern_tstart), 32'd0);
        chk({tag, "_arm_jr"}, 32'(job_ready), 32'd0);
        tick();
        chk({tag, "_start_tstart"}, 32'(kern_tstart), 32'd1);
    endtask

    // From START: idle to counter 4, then write addr k to all banks on k-th cycle.
    task automatic fill_from_c4(input string tag, input bit with_dup, input bit omit_b0a15);
        wr_cycle(16'h0000, 4'd0, 1'b0);
        chk({tag, "_c2_tstart"}, 32'(kern_tstart), 32'd0);
        wr_cycle(16'h0000, 4'd0, 1'b0);
        wr_cycle(16'h0000, 4'd0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            chk({tag, "_run_dv"}, 32'(done_valid), 32'd0);
            chk({tag, "_run_memsel"}, 32'(mem_sel), 32'd1);
            wr_cycle((omit_b0a15 && k == 15) ? 16'hFFFE : 16'hFFFF, 4'(k), 1'b0);
            if (with_dup && k == 7) begin
                wr_cycle(16'h0020, 4'd7, 1'b0);
            end
        end
    endtask

    // Check a held report, then complete the handshake.
    task automatic report_check(input string tag, input logic [1:0] st, input logic [15:0] cyc);
        chk({tag, "_dv"}, 32'(done_valid), 32'd1);
        chk({tag, "_status"}, 32'(done_status), 32'(st));
        chk({tag, "_cycles"}, 32'(done_cycles), 32'(cyc));
        chk({tag, "_rep_memsel"}, 32'(mem_sel), 32'd0);
        chk({tag, "_rep_jr"}, 32'(job_ready), 32'd0);
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
        chk({tag, "_post_dv"}, 32'(done_valid), 32'd0);
        chk({tag, "_post_jr"}, 32'(job_ready), 32'd1);
    endtask

    initial begin
        int n;
        vectors      = 0;
        miscompares  = 0;
        rst_n        = 1'b1;
        job_valid    = 1'b0;
        abort        = 1'b0;
        kern_wr_en   = '0;
        kern_wr_addr = '0;
        done_ready   = 1'b0;

        // Reset values, checked before any clock edge.
        #2 rst_n = 1'b0;
        #2;
        chk("rst_jr", 32'(job_ready), 32'd1);
        chk("rst_tstart", 32'(kern_tstart), 32'd0);
        chk("rst_memsel", 32'(mem_sel), 32'd0);
        chk("rst_dv", 32'(done_valid), 32'd0);
        chk("rst_status", 32'(done_status), 32'd0);
        chk("rst_cycles", 32'(done_cycles), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Nominal: all bits written at counters 4..19.
        start_job("nom");
        fill_from_c4("nom", 1'b0, 1'b0);
        report_check("nom", 2'd0, 16'd19);

        // Duplicate on bank 5 addr 7: report after the last bit, status 2.
        start_job("dup");
        fill_from_c4("dup", 1'b1, 1'b0);
        report_check("dup", 2'd2, 16'd20);

        // Timeout: bank 0 addr 15 never written.
        start_job("tmo");
        fill_from_c4("tmo", 1'b0, 1'b1);
        n = 0;
        while (!done_valid && n < 200) begin
            tick();
            n++;
        end
        chk("tmo_wait_cycles", 32'(n), 32'd45);
        report_check("tmo", 2'd1, 16'd64);

        // Abort coincident with the completing write: full wins.
        start_job("abf");
        for (int k = 0; k < 16; k++) begin
            wr_cycle(16'hFFFF, 4'(k), (k == 15) ? 1'b1 : 1'b0);
        end
        report_check("abf", 2'd0, 16'd16);

        // Abort alone at counter 10, then backpressure on the report.
        start_job("abt");
        for (int k = 0; k < 9; k++) begin
            wr_cycle(16'h00FF, 4'(k), 1'b0);
        end
        wr_cycle(16'h0000, 4'd0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            job_valid    = 1'b1;
            kern_wr_en   = 16'hFFFF;
            abort        = 1'b1;
            chk("bp_dv", 32'(done_valid), 32'd1);
            chk("bp_status", 32'(done_status), 32'd3);
            chk("bp_cycles", 32'(done_cycles), 32'd10);
            chk("bp_jr", 32'(job_ready), 32'd0);
            chk("bp_tstart", 32'(kern_tstart), 32'd0);
            tick();
        end
        job_valid  = 1'b0;
        kern_wr_en = '0;
        abort      = 1'b0;
        report_check("abt", 2'd3, 16'd10);
        tick();
        chk("bp_no_queue_memsel", 32'(mem_sel), 32'd0);
        chk("bp_no_queue_jr", 32'(job_ready), 32'd1);

        // Asynchronous reset in the middle of RUN.
        start_job("rst");
        for (int k = 0; k < 4; k++) begin
            wr_cycle(16'hFFFF, 4'(k), 1'b0);
        end
        chk("mid_memsel_pre", 32'(mem_sel), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_tstart", 32'(kern_tstart), 32'd0);
        chk("mid_memsel", 32'(mem_sel), 32'd0);
        chk("mid_dv", 32'(done_valid), 32'd0);
        chk("mid_jr", 32'(job_ready), 32'd1);
        chk("mid_status", 32'(done_status), 32'd0);
        #2 rst_n = 1'b1;
        tick();
        tick();
        chk("mid_no_report", 32'(done_valid), 32'd0);
        start_job("rerun");
        fill_from_c4("rerun", 1'b0, 1'b0);
        report_check("rerun", 2'd0, 16'd19);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
